// File: rtl/transaction_control.sv
// Purpose : sequences one account transaction (fetch, load, amount check, key check, commit, report).
// Latency : with done_step held high, mem_write rises 4 edges and txn_ok 5 edges after the start-sampling edge.
// Backpressure: none; start is ignored while busy, and CHK_AMT/CHK_KEY stall until done_step, a timeout or abort.
//
// Ports:
//   clock, resetn             - single rising-edge clock, synchronous active-low reset
//   start, abort, done_step   - request, cancel, datapath verification result
//   mem_read, mem_write       - memory fetch / write-back strobes
//   load_register/player/amount/key - datapath latch strobes (all together in LOAD)
//   process[2:0]              - datapath step select (001 amount, 010 key, 100 commit)
//   busy, txn_ok, txn_fail, fail_code[1:0] - status; fail_code 01 amount, 10 key timeout, 11 abort
//
// Build option: define TXN_TIMEOUT_EN to make CHK_KEY give up after KEY_TIMEOUT cycles;
// without it CHK_KEY waits until done_step, abort or reset.

module transaction_control #(
    parameter int AMT_WAIT    = 2,    // 1..15
    parameter int KEY_TIMEOUT = 255   // 1..255
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       done_step,
    output logic       mem_read,
    output logic       load_register,
    output logic       load_player,
    output logic       load_amount,
    output logic       load_key,
    output logic [2:0] process,
    output logic       mem_write,
    output logic       busy,
    output logic       txn_ok,
    output logic       txn_fail,
    output logic [1:0] fail_code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_CHK_AMT = 3'd3,
        S_CHK_KEY = 3'd4,
        S_COMMIT  = 3'd5,
        S_REPORT  = 3'd6
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_AMT   = 2'b01;
    localparam logic [1:0] FC_KEY   = 2'b10;
    localparam logic [1:0] FC_ABORT = 2'b11;

    // The counter holds the number of cycles already spent in the current
    // check state, so the N-th cycle is the one where it equals N-1.
    localparam logic [7:0] AMT_LAST = 8'(AMT_WAIT - 1);
    localparam logic [7:0] KEY_LAST = 8'(KEY_TIMEOUT - 1);

`ifdef TXN_TIMEOUT_EN
    localparam logic KEY_TO_EN = 1'b1;
`else
    localparam logic KEY_TO_EN = 1'b0;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [1:0] r_fail_code;
    logic [1:0] w_fail_code_nxt;

    // Saturating increment: the counter sticks at 255 instead of wrapping.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_fail_code <= FC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fail_code <= w_fail_code_nxt;
        end
    end

    // Next-state logic. Abort is tested first in every abortable state so it
    // wins over done_step and any timeout in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_fail_code_nxt = r_fail_code;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_FETCH;
                    w_cnt_nxt       = 8'd0;
                    w_fail_code_nxt = FC_NONE;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_ABORT;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_ABORT;
                end else begin
                    w_state_nxt = S_CHK_AMT;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_CHK_AMT: begin
                if (abort) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_ABORT;
                end else if (done_step) begin
                    w_state_nxt = S_CHK_KEY;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt >= AMT_LAST) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_AMT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_CHK_KEY: begin
                if (abort) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_ABORT;
                end else if (done_step) begin
                    w_state_nxt = S_COMMIT;
                end else if (KEY_TO_EN && (r_cnt >= KEY_LAST)) begin
                    w_state_nxt     = S_REPORT;
                    w_fail_code_nxt = FC_KEY;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_COMMIT: begin
                // The write always completes; abort is not looked at here.
                w_state_nxt     = S_REPORT;
                w_fail_code_nxt = FC_NONE;
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded only from registered state (and the registered
    // fail code, which is stable for the whole REPORT cycle).
    always_comb begin
        mem_read      = 1'b0;
        load_register = 1'b0;
        load_player   = 1'b0;
        load_amount   = 1'b0;
        load_key      = 1'b0;
        process       = 3'b000;
        mem_write     = 1'b0;
        busy          = (r_state != S_IDLE);
        txn_ok        = 1'b0;
        txn_fail      = 1'b0;
        case (r_state)
            S_FETCH:   mem_read = 1'b1;
            S_LOAD: begin
                load_register = 1'b1;
                load_player   = 1'b1;
                load_amount   = 1'b1;
                load_key      = 1'b1;
            end
            S_CHK_AMT: process = 3'b001;
            S_CHK_KEY: process = 3'b010;
            S_COMMIT: begin
                process   = 3'b100;
                mem_write = 1'b1;
            end
            S_REPORT: begin
                txn_ok   = (r_fail_code == FC_NONE);
                txn_fail = (r_fail_code != FC_NONE);
            end
            default: ;
        endcase
    end

    assign fail_code = r_fail_code;

endmodule
